// File: rtl/pulse_width_decoder.sv
// Pulse-width decoder: measures how many clocks `in` stays high and offers the
// saturated 8-bit width on z/ovf through a dav/rfd four-phase producer handshake.
module pulse_width_decoder (
    input  logic       clock,
    input  logic       reset_,
    input  logic       in,
    input  logic       rfd,
    output logic       dav,
    output logic [7:0] z,
    output logic       ovf
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_OFFER = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] count_q, count_d;
    logic       ovfr_q, ovfr_d;
    logic       in_prev_q;
    logic       dav_q, dav_d;
    logic [7:0] z_q, z_d;
    logic       ovf_q, ovf_d;

    // in_prev_q resets high so a pulse already in progress at reset release
    // cannot look like a fresh rising edge.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q   <= S_IDLE;
            count_q   <= 8'h00;
            ovfr_q    <= 1'b0;
            in_prev_q <= 1'b1;
            dav_q     <= 1'b0;
            z_q       <= 8'h00;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            ovfr_q    <= ovfr_d;
            in_prev_q <= in;
            dav_q     <= dav_d;
            z_q       <= z_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ovfr_d  = ovfr_q;
        dav_d   = dav_q;
        z_d     = z_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (in && !in_prev_q) begin
                    count_d = 8'd1;
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                if (in) begin
                    if (count_q == 8'd255) ovfr_d = 1'b1;
                    else                   count_d = count_q + 8'd1;
                end else begin
                    z_d     = count_q;
                    ovf_d   = ovfr_q;
                    ovfr_d  = 1'b0;
                    state_d = S_OFFER;
                end
            end
            S_OFFER: begin
                if (rfd) begin
                    dav_d   = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (!rfd) begin
                    dav_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign dav = dav_q;
    assign z   = z_q;
    assign ovf = ovf_q;

endmodule
